rv32_pmp_ctrl: RTL and testbench
================================

RV32_PMP_CTRL -- requirements
Module: rv32_pmp_ctrl

Interface
REQ-001 SHALL have parameters XLEN=32 (register width), NB_PMP_REGION=16 (implemented regions, 1..16), MAX_PMP_REGION=16 (architectural maximum).
REQ-002 SHALL have ports:
- aclk  in  1  clock.
- srst  in  1  reset; one clock, reset synchronous and active-high.
- csr_wr_valid  in  1  write request.
- csr_wr_ready  out  1  controller can accept.
- csr_wr_addr  in  12  CSR address.
- csr_wr_op  in  2  00 write, 01 set, 10 clear, 11 reserved.
- csr_wr_data  in  XLEN  operand.
- csr_wr_done  out  1  completion pulse.
- csr_wr_err  out  1  error flag, valid with done.
- csr_rd_addr  in  12  read address.
- csr_rd_data  out  XLEN  read data, combinational.
- pmp_flush  out  1  pipeline flush request.
- pmp_flush_ack  in  1  flush complete.
- csr_sb  out  `CSR_SB_W  pmpcfg0..3 at [4*XLEN-1:0], then pmpaddr0..15 at XLEN each.

Function
REQ-003 SHALL decode pmpcfg0..3 at 0x3A0..0x3A3 and pmpaddr0..15 at 0x3B0..0x3BF; pmpaddr i with i>=NB_PMP_REGION and its cfg byte read as 0 and ignore writes.
REQ-004 SHALL compute new value = data (op 00), old|data (op 01), old&~data (op 10).
REQ-005 SHALL legalise every cfg byte: bits 6:5 forced 0; R=0,W=1 forces W=0.
REQ-006 SHALL keep cfg byte i and pmpaddr i unchanged when L(i)=1.
REQ-007 SHALL keep pmpaddr i unchanged when cfg i+1 has L=1 and A=TOR.
REQ-008 SHALL apply unlocked bytes of a partially locked pmpcfg write.
REQ-009 SHALL use an FSM with states IDLE, FLUSH, DONE; csr_wr_ready=1 only in IDLE.
REQ-010 SHALL update the registers on the accept edge (valid&ready) and go to FLUSH if any stored bit changed, else to DONE.
REQ-011 SHALL hold pmp_flush=1 throughout FLUSH and go to DONE on the first FLUSH cycle with pmp_flush_ack=1; ack outside FLUSH is ignored.
REQ-012 SHALL, in DONE, drive csr_wr_done=1 for exactly one cycle and return to IDLE; minimum accept-to-done is 1 cycle (accept edge, then DONE).
REQ-013 SHALL set csr_wr_err with done for a non-PMP address, op 11, or a write fully blocked by locks; a partial apply gives err=0.
REQ-014 SHALL drive csr_sb continuously from the stored registers, with no additional latency after the update edge.
REQ-015 SHALL return the stored value on csr_rd_data for any decoded address, else 0; reads never stall.

Reset
REQ-016 SHALL on srst clear all pmpcfg/pmpaddr registers, state=IDLE, csr_wr_done=0, csr_wr_err=0, pmp_flush=0, csr_wr_ready=1 in the following cycle.
REQ-017 SHALL abort an in-flight FLUSH on srst with no done pulse; srst overrides an accept in the same cycle.
REQ-018 SHALL not allow lock bits to survive srst.

Configuration
REQ-019 SHALL honour macro PMP_FLUSH_EN: defined -> behaviour per REQ-010/011; undefined -> FLUSH state absent, accept always goes to DONE, pmp_flush tied 0, pmp_flush_ack unused.

Structure
REQ-020 SHALL place in shared package rv32_pmp_pkg: the ADDR_MATCH enum (OFF/TOR/NA4/NAPOT), the FSM state enum, and the CSR address constants. Cfg bit positions SHALL come from the existing PMA_L/X/W/R defines.
REQ-021 SHALL use one sub-module rv32_pmp_cfg_legalize (per-byte WARL legalisation, combinational), instanced per cfg byte.

Verification
REQ-022 Write 0x3A0 data 0x0000_001F op 00 -> cfg0=0x1F, pmp_flush high until ack, done with err=0; csr_sb[7:0]=0x1F.
REQ-023 cfg0=0x80 (L) then write 0x3B0 data 0x1234 -> pmpaddr0 unchanged, no flush, done next cycle with err=1.
REQ-024 cfg1=0x88 (L, TOR) then write 0x3B0 data 0x100 -> pmpaddr0 unchanged, err=1; write 0x3B2 data 0x100 -> applied, err=0.
REQ-025 Write cfg byte 0x62 (W=1, R=0, reserved bits set) -> stored 0x00, no flush.
REQ-026 srst asserted during FLUSH with ack low -> next cycle pmp_flush=0, ready=1, all regs 0, no done pulse.
REQ-027 Set op on 0x3A0 data 0x0100 with byte1 locked -> byte1 unchanged, other bytes applied, err=0; ack held high entering FLUSH -> pmp_flush high exactly 1 cycle.

Source files
------------

// File: rtl/rv32_pmp_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pmp_pkg
// Shared types and constants for the RV32 PMP CSR controller.
// Contents:
//   - PMA_L/X/W/R   cfg-byte bit positions (defaults provided if not already defined)
//   - CSR_SB_W      width of the flattened CSR sideband bus (4 cfg words + 16 addrs)
//   - addr_match_e  the A field encoding (OFF/TOR/NA4/NAPOT)
//   - pmp_state_e   controller FSM state (FLUSH only exists with PMP_FLUSH_EN)
//   - csr_op_e      write / set / clear operation encoding
//   - CSR address constants and small decode helpers
// ---------------------------------------------------------------------------
`ifndef PMA_R
`define PMA_R 0
`endif
`ifndef PMA_W
`define PMA_W 1
`endif
`ifndef PMA_X
`define PMA_X 2
`endif
`ifndef PMA_L
`define PMA_L 7
`endif
`ifndef CSR_SB_W
`define CSR_SB_W 640
`endif

package rv32_pmp_pkg;

  typedef enum logic [1:0] {
    A_OFF   = 2'b00,
    A_TOR   = 2'b01,
    A_NA4   = 2'b10,
    A_NAPOT = 2'b11
  } addr_match_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef PMP_FLUSH_EN
    ST_FLUSH = 2'd1,
`endif
    ST_DONE  = 2'd2
  } pmp_state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

  // Lowest bit of the 2-bit A field inside a cfg byte.
  localparam int A_LSB = 3;

  // pmpcfg0..3 occupy 0x3A0..0x3A3.
  function automatic logic is_cfg_csr(input logic [11:0] a);
    return a[11:2] == CSR_PMPCFG0[11:2];
  endfunction

  // pmpaddr0..15 occupy 0x3B0..0x3BF.
  function automatic logic is_addr_csr(input logic [11:0] a);
    return a[11:4] == CSR_PMPADDR0[11:4];
  endfunction

  // A locked TOR entry also freezes the pmpaddr below it (its base).
  function automatic logic tor_locked(input logic [7:0] cfg);
    return cfg[`PMA_L] && (addr_match_e'(cfg[A_LSB+1:A_LSB]) == A_TOR);
  endfunction

endpackage

// File: rtl/rv32_pmp_cfg_legalize.sv
// ---------------------------------------------------------------------------
// rv32_pmp_cfg_legalize
// Combinational WARL legalisation of one pmpcfg byte.
// Ports:
//   cfg_in   [7:0]  candidate byte after the write/set/clear operation
//   cfg_out  [7:0]  legal byte to be stored
// Rules: reserved bits 6:5 read as zero; the reserved R=0/W=1 combination
// is turned into R=0/W=0.
// ---------------------------------------------------------------------------
module rv32_pmp_cfg_legalize
  import rv32_pmp_pkg::*;
(
  input  logic [7:0] cfg_in,
  output logic [7:0] cfg_out
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cfg_out      = cfg_in;
    cfg_out[6:5] = 2'b00;
    if (!cfg_in[`PMA_R] && cfg_in[`PMA_W]) begin
      cfg_out[`PMA_W] = 1'b0;
    end
  end

endmodule

// File: rtl/rv32_pmp_ctrl.sv
// ---------------------------------------------------------------------------
// rv32_pmp_ctrl
// PMP CSR controller: holds pmpcfg0..3 / pmpaddr0..15, applies write/set/clear
// operations with WARL legalisation and lock rules, and sequences each write
// through IDLE -> (FLUSH) -> DONE.
// Build option: PMP_FLUSH_EN -- when defined, a write that changes any stored
// bit raises pmp_flush until pmp_flush_ack; when undefined, every accepted
// write goes straight to DONE and pmp_flush is tied low.
// Ports:
//   aclk, srst                    clock, synchronous active-high reset
//   csr_wr_valid/ready            write request handshake
//   csr_wr_addr/op/data           CSR address, 00 write 01 set 10 clear, operand
//   csr_wr_done/err               one-cycle completion pulse and its error flag
//   csr_rd_addr/data              combinational read port
//   pmp_flush/pmp_flush_ack       pipeline flush request / completion
//   csr_sb                        pmpcfg0..3 in the low 4*XLEN bits, then pmpaddr0..15
// ---------------------------------------------------------------------------
module rv32_pmp_ctrl
  import rv32_pmp_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NB_PMP_REGION  = 16,
  parameter int MAX_PMP_REGION = 16
) (
  input  logic                 aclk,
  input  logic                 srst,
  input  logic                 csr_wr_valid,
  output logic                 csr_wr_ready,
  input  logic [11:0]          csr_wr_addr,
  input  logic [1:0]           csr_wr_op,
  input  logic [XLEN-1:0]      csr_wr_data,
  output logic                 csr_wr_done,
  output logic                 csr_wr_err,
  input  logic [11:0]          csr_rd_addr,
  output logic [XLEN-1:0]      csr_rd_data,
  output logic                 pmp_flush,
  input  logic                 pmp_flush_ack,
  output logic [`CSR_SB_W-1:0] csr_sb
);

  logic [7:0]      cfg_q     [MAX_PMP_REGION];
  logic [XLEN-1:0] addr_q    [MAX_PMP_REGION];
  logic [7:0]      cfg_legal [MAX_PMP_REGION];
  logic [31:0]     cfg_word  [4];

  logic [MAX_PMP_REGION-1:0] tor_lk;
  logic [MAX_PMP_REGION-1:0] cfg_we;
  logic [MAX_PMP_REGION-1:0] addr_we;

  logic            wr_is_cfg;
  logic            wr_is_addr;
  logic            op_ok;
  logic [XLEN-1:0] wr_old;
  logic [XLEN-1:0] new_val;
  logic            wr_locked;
  logic            wr_applied;
  logic            wr_change;
  logic            wr_err;
  logic            accept;

  pmp_state_e      state;

  // Packed view of the cfg bytes, four per pmpcfg word.
  always_comb begin
    for (int w = 0; w < 4; w++) begin
      cfg_word[w] = {cfg_q[4*w+3], cfg_q[4*w+2], cfg_q[4*w+1], cfg_q[4*w]};
    end
  end

  // pmpaddr i is frozen by a locked TOR entry i+1; the top entry has no i+1.
  always_comb begin
    tor_lk = '0;
    for (int i = 0; i < MAX_PMP_REGION - 1; i++) begin
      tor_lk[i] = tor_locked(cfg_q[i+1]);
    end
  end

  // Read port: unimplemented entries were never written, so they read as 0.
  always_comb begin
    csr_rd_data = '0;
    if (is_cfg_csr(csr_rd_addr)) begin
      csr_rd_data = XLEN'(cfg_word[csr_rd_addr[1:0]]);
    end else if (is_addr_csr(csr_rd_addr) && (int'(csr_rd_addr[3:0]) < NB_PMP_REGION)) begin
      csr_rd_data = addr_q[csr_rd_addr[3:0]];
    end
  end

  // Operand combine: the old value is what a read of the same CSR returns.
  always_comb begin
    wr_is_cfg  = is_cfg_csr(csr_wr_addr);
    wr_is_addr = is_addr_csr(csr_wr_addr);
    op_ok      = csr_op_e'(csr_wr_op) != OP_RSVD;
    wr_old     = '0;
    if (wr_is_cfg) begin
      wr_old = XLEN'(cfg_word[csr_wr_addr[1:0]]);
    end else if (wr_is_addr) begin
      wr_old = addr_q[csr_wr_addr[3:0]];
    end
    case (csr_op_e'(csr_wr_op))
      OP_WRITE: new_val = csr_wr_data;
      OP_SET:   new_val = wr_old | csr_wr_data;
      OP_CLEAR: new_val = wr_old & ~csr_wr_data;
      default:  new_val = wr_old;
    endcase
  end

  // One legaliser per cfg byte; each sees its lane of the combined word.
  for (genvar g = 0; g < MAX_PMP_REGION; g++) begin : g_legal
    rv32_pmp_cfg_legalize u_legal (
      .cfg_in  (new_val[(g%4)*8 +: 8]),
      .cfg_out (cfg_legal[g])
    );
  end

  // Per-entry write enables, lock filtering and change detection.
  always_comb begin
    cfg_we     = '0;
    addr_we    = '0;
    wr_locked  = 1'b0;
    wr_applied = 1'b0;
    wr_change  = 1'b0;
    for (int i = 0; i < NB_PMP_REGION; i++) begin
      logic [3:0] ridx;
      ridx = 4'(i);
      if (op_ok && wr_is_cfg && (csr_wr_addr[1:0] == ridx[3:2])) begin
        if (cfg_q[i][`PMA_L]) begin
          wr_locked = 1'b1;
        end else begin
          cfg_we[i]  = 1'b1;
          wr_applied = 1'b1;
          if (cfg_legal[i] != cfg_q[i]) wr_change = 1'b1;
        end
      end
      if (op_ok && wr_is_addr && (csr_wr_addr[3:0] == ridx)) begin
        if (cfg_q[i][`PMA_L] || tor_lk[i]) begin
          wr_locked = 1'b1;
        end else begin
          addr_we[i] = 1'b1;
          wr_applied = 1'b1;
          if (new_val != addr_q[i]) wr_change = 1'b1;
        end
      end
    end
    // A write with at least one applied byte is a partial success, not an error.
    wr_err = !(wr_is_cfg || wr_is_addr) || !op_ok || (wr_locked && !wr_applied);
  end

  assign accept = csr_wr_valid && csr_wr_ready;

  // NOTE: the PMP registers are architectural state (including lock bits),
  // so they are reset explicitly rather than left as uninitialised storage.
  always_ff @(posedge aclk) begin
    if (srst) begin
      for (int i = 0; i < MAX_PMP_REGION; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < MAX_PMP_REGION; i++) begin
        if (cfg_we[i])  cfg_q[i]  <= cfg_legal[i];
        if (addr_we[i]) addr_q[i] <= new_val;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state        <= ST_IDLE;
      csr_wr_ready <= 1'b1;
      csr_wr_done  <= 1'b0;
      csr_wr_err   <= 1'b0;
`ifdef PMP_FLUSH_EN
      pmp_flush    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (csr_wr_valid) begin
            csr_wr_ready <= 1'b0;
            csr_wr_err   <= wr_err;
`ifdef PMP_FLUSH_EN
            if (wr_change) begin
              state     <= ST_FLUSH;
              pmp_flush <= 1'b1;
            end else begin
              state       <= ST_DONE;
              csr_wr_done <= 1'b1;
            end
`else
            state       <= ST_DONE;
            csr_wr_done <= 1'b1;
`endif
          end
        end
`ifdef PMP_FLUSH_EN
        ST_FLUSH: begin
          if (pmp_flush_ack) begin
            state       <= ST_DONE;
            pmp_flush   <= 1'b0;
            csr_wr_done <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          state        <= ST_IDLE;
          csr_wr_done  <= 1'b0;
          csr_wr_err   <= 1'b0;
          csr_wr_ready <= 1'b1;
        end
        default: begin
          state        <= ST_IDLE;
          csr_wr_ready <= 1'b1;
          csr_wr_done  <= 1'b0;
          csr_wr_err   <= 1'b0;
        end
      endcase
    end
  end

`ifndef PMP_FLUSH_EN
  logic unused_flush_sigs;
  assign pmp_flush         = 1'b0;
  assign unused_flush_sigs = ^{pmp_flush_ack, wr_change};
`endif

  // Sideband mirrors the registers directly: visible right after the update edge.
  for (genvar w = 0; w < 4; w++) begin : g_sb_cfg
    assign csr_sb[w*XLEN +: XLEN] = XLEN'(cfg_word[w]);
  end
  for (genvar r = 0; r < MAX_PMP_REGION; r++) begin : g_sb_addr
    assign csr_sb[(4+r)*XLEN +: XLEN] = addr_q[r];
  end

endmodule

// File: tb/tb_rv32_pmp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32_pmp_ctrl
// Directed self-checking bench for rv32_pmp_ctrl. Works in both builds
// (PMP_FLUSH_EN defined or not); flush expectations follow the build.
// ---------------------------------------------------------------------------
`ifndef CSR_SB_W
`define CSR_SB_W 640
`endif

module tb_rv32_pmp_ctrl;

  logic                 aclk = 1'b0;
  logic                 srst;
  logic                 csr_wr_valid;
  logic                 csr_wr_ready;
  logic [11:0]          csr_wr_addr;
  logic [1:0]           csr_wr_op;
  logic [31:0]          csr_wr_data;
  logic                 csr_wr_done;
  logic                 csr_wr_err;
  logic [11:0]          csr_rd_addr;
  logic [31:0]          csr_rd_data;
  logic                 pmp_flush;
  logic                 pmp_flush_ack;
  logic [`CSR_SB_W-1:0] csr_sb;

  int checks = 0;
  int errors = 0;

  rv32_pmp_ctrl #(
    .XLEN           (32),
    .NB_PMP_REGION  (16),
    .MAX_PMP_REGION (16)
  ) dut (
    .aclk          (aclk),
    .srst          (srst),
    .csr_wr_valid  (csr_wr_valid),
    .csr_wr_ready  (csr_wr_ready),
    .csr_wr_addr   (csr_wr_addr),
    .csr_wr_op     (csr_wr_op),
    .csr_wr_data   (csr_wr_data),
    .csr_wr_done   (csr_wr_done),
    .csr_wr_err    (csr_wr_err),
    .csr_rd_addr   (csr_rd_addr),
    .csr_rd_data   (csr_rd_data),
    .pmp_flush     (pmp_flush),
    .pmp_flush_ack (pmp_flush_ack),
    .csr_sb        (csr_sb)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_rd_addr = a;
    #1;
    check(tag, csr_rd_data, exp);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    srst = 1'b1;
    @(posedge aclk);
    #1;
    srst = 1'b0;
  endtask

  // One complete write transaction. exp_flush says whether the write changes
  // stored state (only visible as a flush when the build enables it).
  task automatic csr_write(input string tag, input logic [11:0] a, input logic [1:0] op,
                           input logic [31:0] d, input logic exp_err,
                           input logic exp_flush, input logic ack_early);
    @(negedge aclk);
    check({tag, " ready"}, csr_wr_ready, 1);
    csr_wr_addr   = a;
    csr_wr_op     = op;
    csr_wr_data   = d;
    csr_wr_valid  = 1'b1;
    pmp_flush_ack = ack_early;
    @(posedge aclk);
    #1;
    csr_wr_valid = 1'b0;
`ifdef PMP_FLUSH_EN
    if (exp_flush) begin
      @(negedge aclk);
      check({tag, " flush up"}, pmp_flush, 1);
      check({tag, " no early done"}, csr_wr_done, 0);
      if (!ack_early) begin
        @(posedge aclk);
        @(negedge aclk);
        check({tag, " flush held"}, pmp_flush, 1);
        pmp_flush_ack = 1'b1;
      end
      @(posedge aclk);
      #1;
      pmp_flush_ack = 1'b0;
    end
`endif
    @(negedge aclk);
    check({tag, " done"}, csr_wr_done, 1);
    check({tag, " flush low"}, pmp_flush, 0);
    check({tag, " err"}, csr_wr_err, exp_err);
    pmp_flush_ack = 1'b0;
    @(negedge aclk);
    check({tag, " done pulse"}, csr_wr_done, 0);
    check({tag, " ready back"}, csr_wr_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    srst          = 1'b0;
    csr_wr_valid  = 1'b0;
    csr_wr_addr   = '0;
    csr_wr_op     = '0;
    csr_wr_data   = '0;
    csr_rd_addr   = '0;
    pmp_flush_ack = 1'b0;

    // Reset state
    do_reset();
    @(negedge aclk);
    check("rst ready", csr_wr_ready, 1);
    check("rst done", csr_wr_done, 0);
    check("rst err", csr_wr_err, 0);
    check("rst flush", pmp_flush, 0);
    check("rst sb", csr_sb == '0, 1);
    rd_check("rst cfg0", 12'h3A0, 32'h0);

    // Basic write / set / clear and legalisation
    csr_write("cfg0 wr 1F", 12'h3A0, 2'b00, 32'h0000_001F, 0, 1, 0);
    rd_check("cfg0 rd 1F", 12'h3A0, 32'h0000_001F);
    check("sb cfg0", csr_sb[7:0], 8'h1F);
    csr_write("cfg0 set", 12'h3A0, 2'b01, 32'h0000_0300, 0, 1, 0);
    rd_check("cfg0 rd set", 12'h3A0, 32'h0000_031F);
    csr_write("cfg0 clr", 12'h3A0, 2'b10, 32'h0000_001F, 0, 1, 0);
    rd_check("cfg0 rd clr", 12'h3A0, 32'h0000_0300);
    csr_write("cfg0 wr 62", 12'h3A0, 2'b00, 32'h0000_0362, 0, 0, 0);
    rd_check("cfg0 rd legal", 12'h3A0, 32'h0000_0300);
    csr_write("addr0 wr", 12'h3B0, 2'b00, 32'h1234_5678, 0, 1, 0);
    rd_check("addr0 rd", 12'h3B0, 32'h1234_5678);
    check("sb addr0", csr_sb[128 +: 32], 32'h1234_5678);
    csr_write("addr15 wr", 12'h3BF, 2'b00, 32'hDEAD_BEEF, 0, 1, 0);
    check("sb addr15", csr_sb[608 +: 32], 32'hDEAD_BEEF);
    csr_write("addr0 same", 12'h3B0, 2'b00, 32'h1234_5678, 0, 0, 0);
    csr_write("op rsvd", 12'h3B1, 2'b11, 32'h0000_FFFF, 1, 0, 0);
    rd_check("addr1 rsvd", 12'h3B1, 32'h0);
    csr_write("non pmp", 12'h300, 2'b00, 32'h0000_00FF, 1, 0, 0);
    rd_check("rd unmapped 3C0", 12'h3C0, 32'h0);
    rd_check("rd unmapped 3A4", 12'h3A4, 32'h0);

    // Lock on entry 0
    do_reset();
    csr_write("lock cfg0", 12'h3A0, 2'b00, 32'h0000_0080, 0, 1, 0);
    csr_write("addr0 locked", 12'h3B0, 2'b00, 32'h0000_1234, 1, 0, 0);
    rd_check("addr0 kept", 12'h3B0, 32'h0);
    csr_write("cfg0 partial", 12'h3A0, 2'b00, 32'h0000_0000, 0, 0, 0);
    rd_check("cfg0 kept L", 12'h3A0, 32'h0000_0080);
    csr_write("cfg1 apply", 12'h3A0, 2'b00, 32'h0000_0500, 0, 1, 0);
    rd_check("cfg0 partial rd", 12'h3A0, 32'h0000_0580);

    // Locked TOR entry 1 freezes pmpaddr0 and pmpaddr1, not pmpaddr2
    do_reset();
    csr_write("lock tor1", 12'h3A0, 2'b00, 32'h0000_8800, 0, 1, 0);
    csr_write("addr0 tor lk", 12'h3B0, 2'b00, 32'h0000_0100, 1, 0, 0);
    rd_check("addr0 tor kept", 12'h3B0, 32'h0);
    csr_write("addr1 lk", 12'h3B1, 2'b00, 32'h0000_0100, 1, 0, 0);
    csr_write("addr2 ok", 12'h3B2, 2'b00, 32'h0000_0100, 0, 1, 0);
    rd_check("addr2 rd", 12'h3B2, 32'h0000_0100);

    // Set with byte 1 locked, ack already high when FLUSH is entered
    csr_write("set part", 12'h3A0, 2'b01, 32'h0000_0103, 0, 1, 1);
    rd_check("set part rd", 12'h3A0, 32'h0000_8803);

    // Reset while the write is in flight
    @(negedge aclk);
    csr_wr_addr  = 12'h3B5;
    csr_wr_op    = 2'b00;
    csr_wr_data  = 32'h0000_00AA;
    csr_wr_valid = 1'b1;
    @(posedge aclk);
    #1;
    csr_wr_valid = 1'b0;
    @(negedge aclk);
`ifdef PMP_FLUSH_EN
    check("inflight flush", pmp_flush, 1);
`endif
    srst = 1'b1;
    @(posedge aclk);
    #1;
    srst = 1'b0;
    @(negedge aclk);
    check("abort flush", pmp_flush, 0);
    check("abort ready", csr_wr_ready, 1);
    check("abort done", csr_wr_done, 0);
    check("abort sb", csr_sb == '0, 1);
    rd_check("abort cfg0", 12'h3A0, 32'h0);
    @(negedge aclk);
    check("abort no pulse", csr_wr_done, 0);
    csr_write("addr1 unlocked", 12'h3B1, 2'b00, 32'h0000_0055, 0, 1, 0);
    rd_check("addr1 rd", 12'h3B1, 32'h0000_0055);

    // Reset wins over an accept in the same cycle
    @(negedge aclk);
    csr_wr_addr  = 12'h3B3;
    csr_wr_op    = 2'b00;
    csr_wr_data  = 32'h0000_0077;
    csr_wr_valid = 1'b1;
    srst         = 1'b1;
    @(posedge aclk);
    #1;
    csr_wr_valid = 1'b0;
    srst         = 1'b0;
    @(negedge aclk);
    rd_check("rst vs accept", 12'h3B3, 32'h0);
    check("rst vs acc done", csr_wr_done, 0);
    check("rst vs acc ready", csr_wr_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
